warp_ctl_arbiter: RTL and testbench



---
 rtl/gpu_types.sv | 46 ++++
 rtl/warp_ctl_arbiter_queue.sv | 53 +++++
 rtl/warp_ctl_arbiter.sv | 114 +++++++++++
 tb/tb_warp_ctl_arbiter.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_types.sv
// Shared GPU warp-control types. wctl_req_t bundles the per-warp control fields.
// NW_BITS (the warp-id width) may be overridden from the command line.
`ifndef NW_BITS
`define NW_BITS 4
`endif

package gpu_types;

    localparam int NW_BITS     = `NW_BITS;
    localparam int NUM_THREADS = 4;
    localparam int NUM_WARPS   = 1 << NW_BITS;

    typedef struct packed {
        logic                   valid;
        logic [NUM_THREADS-1:0] tmask;
    } gpu_tmc_t;

    typedef struct packed {
        logic                   valid;
        logic [NUM_THREADS-1:0] wmask;
        logic [31:0]            pc;
    } gpu_wspawn_t;

    typedef struct packed {
        logic               valid;
        logic [NW_BITS-1:0] id;
        logic [NW_BITS-1:0] size_m1;
    } gpu_barrier_t;

    typedef struct packed {
        logic                   valid;
        logic                   diverged;
        logic [NUM_THREADS-1:0] then_tmask;
        logic [NUM_THREADS-1:0] else_tmask;
        logic [31:0]            pc;
    } gpu_split_t;

    typedef struct packed {
        logic [NW_BITS-1:0] wid;
        gpu_tmc_t           tmc;
        gpu_wspawn_t        wspawn;
        gpu_barrier_t       barrier;
        gpu_split_t         split;
    } wctl_req_t;

endpackage

// File: rtl/warp_ctl_arbiter_queue.sv
// wctl_queue: single-channel FIFO of warp-control bundles with async reset.
// Push is ignored when full and pop when empty; storage is not reset, only count/pointers.
module wctl_queue
    import gpu_types::*;
#(
    parameter int DEPTH = 2
) (
    input  logic      clk,
    input  logic      reset,
    input  logic      push,
    input  logic      pop,
    input  wctl_req_t din,
    output wctl_req_t dout,
    output logic      empty,
    output logic      full
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    wctl_req_t      mem [DEPTH];
    logic [AW-1:0]  rd_ptr;
    logic [AW-1:0]  wr_ptr;
    logic [AW:0]    count;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/warp_ctl_arbiter.sv
// Multi-channel warp-control arbiter: per-channel queues, round-robin grant, registered output.
// Optional macro VX_WCTL_PERF_EN adds perf_grants/perf_stalls counters.
module warp_ctl_arbiter
    import gpu_types::*;
#(
    parameter int NUM_REQS    = 4,
    parameter int QUEUE_DEPTH = 2,
    localparam int SRC_W      = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQS-1:0]   req_valid,
    input  wctl_req_t [NUM_REQS-1:0] req_data,
    output logic [NUM_REQS-1:0]   req_ready,
    output logic                  ctl_valid,
    output wctl_req_t             ctl_data,
    output logic [SRC_W-1:0]      ctl_src,
    input  logic                  ctl_ready
`ifdef VX_WCTL_PERF_EN
    ,
    output logic [31:0]           perf_grants,
    output logic [31:0]           perf_stalls
`endif
);

    logic [NUM_REQS-1:0] push;
    logic [NUM_REQS-1:0] pop;
    logic [NUM_REQS-1:0] empty;
    logic [NUM_REQS-1:0] full;
    wctl_req_t           head [NUM_REQS];

    logic [SRC_W-1:0]    rr;
    logic                grant_valid;
    logic [SRC_W-1:0]    grant_idx;
    logic                load;

    // Ready is held low by reset itself so it drops the moment reset asserts.
    assign req_ready = reset ? '0 : ~full;
    assign push      = req_valid & req_ready;

    for (genvar i = 0; i < NUM_REQS; i++) begin : g_q
        wctl_queue #(
            .DEPTH (QUEUE_DEPTH)
        ) u_q (
            .clk   (clk),
            .reset (reset),
            .push  (push[i]),
            .pop   (pop[i]),
            .din   (req_data[i]),
            .dout  (head[i]),
            .empty (empty[i]),
            .full  (full[i])
        );
    end

    always_comb begin
        int unsigned idx;
        grant_valid = 1'b0;
        grant_idx   = '0;
        idx         = 0;
        for (int unsigned k = 0; k < NUM_REQS; k++) begin
            idx = int'(rr) + k;
            if (idx >= NUM_REQS) idx = idx - NUM_REQS;
            if (!grant_valid && !empty[idx]) begin
                grant_valid = 1'b1;
                grant_idx   = SRC_W'(idx);
            end
        end
    end

    assign load = (!ctl_valid || ctl_ready) && grant_valid;

    always_comb begin
        pop = '0;
        for (int unsigned i = 0; i < NUM_REQS; i++) begin
            pop[i] = load && (grant_idx == SRC_W'(i));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr <= '0;
        end else if (load) begin
            rr <= (grant_idx == SRC_W'(NUM_REQS - 1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ctl_valid <= 1'b0;
            ctl_data  <= '0;
            ctl_src   <= '0;
        end else if (load) begin
            ctl_valid <= 1'b1;
            ctl_data  <= head[grant_idx];
            ctl_src   <= grant_idx;
        end else if (ctl_ready) begin
            ctl_valid <= 1'b0;
        end
    end

`ifdef VX_WCTL_PERF_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_grants <= '0;
            perf_stalls <= '0;
        end else begin
            if (ctl_valid && ctl_ready)  perf_grants <= perf_grants + 32'd1;
            if (ctl_valid && !ctl_ready) perf_stalls <= perf_stalls + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_warp_ctl_arbiter.sv
// Scoreboard bench for warp_ctl_arbiter (NUM_REQS=4, QUEUE_DEPTH=2).
module tb_warp_ctl_arbiter;
    import gpu_types::*;

    localparam int N = 4;

    logic                clk = 1'b0;
    logic                reset;
    logic [N-1:0]        req_valid;
    wctl_req_t [N-1:0]   req_data;
    logic [N-1:0]        req_ready;
    logic                ctl_valid;
    wctl_req_t           ctl_data;
    logic [1:0]          ctl_src;
    logic                ctl_ready;
`ifdef VX_WCTL_PERF_EN
    logic [31:0]         perf_grants;
    logic [31:0]         perf_stalls;
`endif

    always #5 clk = ~clk;

    warp_ctl_arbiter #(
        .NUM_REQS    (N),
        .QUEUE_DEPTH (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .ctl_valid   (ctl_valid),
        .ctl_data    (ctl_data),
        .ctl_src     (ctl_src),
        .ctl_ready   (ctl_ready)
`ifdef VX_WCTL_PERF_EN
        ,
        .perf_grants (perf_grants),
        .perf_stalls (perf_stalls)
`endif
    );

    int          checks = 0;
    int          errors = 0;
    wctl_req_t   exp_q [N][$];
    int          exp_src [$];
    int          nxt [N];
    int unsigned exp_grants;
    int unsigned exp_stalls;
    int          acc;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic wctl_req_t mk(input int ch, input int n);
        wctl_req_t r;
        r              = '0;
        r.wid          = NW_BITS'(n);
        r.tmc.valid    = 1'b1;
        r.tmc.tmask    = 4'(ch + 1);
        r.wspawn.pc    = 32'(ch * 256 + n);
        r.barrier.id   = NW_BITS'(n + ch);
        r.split.pc     = 32'(n * 7 + ch);
        return r;
    endfunction

    task automatic refresh_data();
        for (int i = 0; i < N; i++) req_data[i] = mk(i, nxt[i]);
    endtask

    task automatic clear_sb();
        for (int i = 0; i < N; i++) exp_q[i].delete();
        exp_src.delete();
        exp_grants = 0;
        exp_stalls = 0;
    endtask

    // Record handshakes that the next rising edge will perform, then advance to the following negedge.
    task automatic tick();
        wctl_req_t e;
        int        s;
        for (int i = 0; i < N; i++) begin
            if (req_valid[i] && req_ready[i]) begin
                exp_q[i].push_back(req_data[i]);
                nxt[i]++;
            end
        end
        if (ctl_valid && ctl_ready) begin
            exp_grants++;
            s = int'(ctl_src);
            check("sb_nonempty", 128'(exp_q[s].size() != 0), 128'(1));
            if (exp_q[s].size() != 0) begin
                e = exp_q[s].pop_front();
                check("sb_data", ctl_data, e);
            end
            if (exp_src.size() != 0) check("rr_src", ctl_src, exp_src.pop_front());
        end
        if (ctl_valid && !ctl_ready) exp_stalls++;
        @(negedge clk);
        refresh_data();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        ctl_ready = 1'b0;
        for (int i = 0; i < N; i++) nxt[i] = 0;
        refresh_data();
        clear_sb();

        repeat (2) @(negedge clk);
        check("rst_valid", ctl_valid, 0);
        check("rst_ready", req_ready, 0);
        check("rst_src",   ctl_src, 0);
        check("rst_data",  ctl_data, 0);
        reset = 1'b0;
        #1;
        check("rel_ready", req_ready, 4'hF);

        // single push on channel 2, one-cycle latency
        ctl_ready = 1'b1;
        nxt[2]    = 5;
        refresh_data();
        req_valid = 4'b0100;
        tick();
        req_valid = '0;
        check("lat_e0_valid", ctl_valid, 0);
        tick();
        check("single_valid", ctl_valid, 1);
        check("single_src",   ctl_src, 2);
        check("single_wid",   ctl_data.wid, 5);
        check("single_tmc",   ctl_data.tmc.valid, 1);
        check("single_rdy2",  req_ready[2], 1);
        tick();
        check("single_done",  ctl_valid, 0);

        // fill channel 0 against a stalled output
        ctl_ready = 1'b0;
        req_valid = 4'b0001;
        acc = 0;
        for (int k = 0; k < 6; k++) begin
            if (req_ready[0]) acc++;
            tick();
        end
        check("fill_accepts", acc, 3);
        check("fill_rdy0",    req_ready[0], 0);
        check("fill_valid",   ctl_valid, 1);

        // output holds while stalled; 4th push remains pending
        for (int k = 0; k < 5; k++) begin
            tick();
            check("hold_data", ctl_data, mk(0, 0));
            check("hold_src",  ctl_src, 0);
            check("hold_rdy0", req_ready[0], 0);
        end

        // full queue popped this cycle still rejects the push
        ctl_ready = 1'b1;
        check("fullpop_rdy0", req_ready[0], 0);
        tick();
        check("afterpop_rdy0", req_ready[0], 1);
        tick();
        req_valid = '0;
        for (int k = 0; k < 10 && ctl_valid; k++) tick();
        check("drain_idle", ctl_valid, 0);
        check("drain_sb",   exp_q[0].size(), 0);

        // fairness from a fresh reset
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        clear_sb();
        #1;
        ctl_ready = 1'b0;
        req_valid = 4'hF;
        for (int k = 0; k < 6; k++) tick();
        req_valid = '0;
        check("fair_full", req_ready, 0);
        foreach (exp_src[i]) exp_src[i] = 0;
        for (int k = 0; k < 9; k++) exp_src.push_back(k % N);
        ctl_ready = 1'b1;
        for (int k = 0; k < 9; k++) begin
            check("thru_valid", ctl_valid, 1);
            tick();
        end
        check("fair_done",  exp_src.size(), 0);
        check("fair_idle",  ctl_valid, 0);

        // asynchronous reset in the middle of traffic
        ctl_ready = 1'b0;
        req_valid = 4'b0011;
        repeat (3) tick();
        req_valid = '0;
        #2 reset = 1'b1;
        #1;
        check("mid_rst_valid", ctl_valid, 0);
        check("mid_rst_ready", req_ready, 0);
        check("mid_rst_data",  ctl_data, 0);
        clear_sb();
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_rel_ready", req_ready, 4'hF);
        ctl_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("no_stale", ctl_valid, 0);
        end

`ifdef VX_WCTL_PERF_EN
        check("perf_grants", perf_grants, exp_grants);
        check("perf_stalls", perf_stalls, exp_stalls);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
